vga_text_writer: RTL and testbench

VGA_TEXT_WRITER -- requirements
Module: vga_text_writer

---
 rtl/vga_text_writer_pkg.sv | 38 +++
 rtl/vga_text_writer.sv | 167 ++++++++++++++++
 tb/tb_vga_text_writer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_writer_pkg.sv
// Shared geometry, control codes, state encoding and cell-address helpers for
// the text-mode writer.
package vga_text_writer_pkg;

  localparam int unsigned COLS   = 64;
  localparam int unsigned ROWS   = 24;
  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned X_W    = 6;
  localparam int unsigned Y_W    = 5;
  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] LF    = 8'h0A;
  localparam logic [DATA_W-1:0] CR    = 8'h0D;
  localparam logic [DATA_W-1:0] BS    = 8'h08;
  localparam logic [DATA_W-1:0] FF    = 8'h0C;
  localparam logic [DATA_W-1:0] SPACE = 8'h20;
  localparam logic [DATA_W-1:0] TILDE = 8'h7E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_FILL
  } state_t;

  // COLS is a power of two, so x + y*COLS is a plain concatenation.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    return {y, x};
  endfunction

  function automatic logic is_printable(input logic [DATA_W-1:0] c);
    return (c >= SPACE) && (c <= TILDE);
  endfunction

endpackage

// File: rtl/vga_text_writer.sv
// Character-stream writer for a 64x24 text buffer: places glyphs, handles
// LF/CR/BS/FF, and scrolls the buffer up one row when the cursor runs off the bottom.
module vga_text_writer
  import vga_text_writer_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [DATA_W-1:0] char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [X_W-1:0]    cursor_x,
  output logic [Y_W-1:0]    cursor_y,
  output logic              busy
);

  localparam logic [X_W-1:0]    LAST_X      = X_W'(COLS - 1);
  localparam logic [Y_W-1:0]    LAST_Y      = Y_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'(CELLS - COLS - 1);
  localparam logic [ADDR_W-1:0] FILL_LAST   = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(COLS);

  state_t              state;
  state_t              state_next;
  logic [X_W-1:0]      cur_x;
  logic [Y_W-1:0]      cur_y;
  logic [X_W-1:0]      nx_x;
  logic [Y_W-1:0]      nx_y;
  logic [ADDR_W-1:0]   idx;
  logic [DATA_W-1:0]   char_q;
  logic                ready_q;
  logic                accept;
  logic                ex_wr;
  logic                ex_scroll;
  logic                ex_fill;
  logic [ADDR_W-1:0]   ex_addr;
  logic [DATA_W-1:0]   ex_data;

  assign accept     = char_valid & ready_q;
  assign char_ready = ready_q;
  assign busy       = ~ready_q;
  assign cursor_x   = cur_x;
  assign cursor_y   = cur_y;

  // Decode of the latched character against the current cursor.
  always_comb begin
    ex_wr     = 1'b0;
    ex_scroll = 1'b0;
    ex_fill   = 1'b0;
    ex_addr   = cell_addr(cur_x, cur_y);
    ex_data   = char_q;
    nx_x      = cur_x;
    nx_y      = cur_y;
    case (char_q)
      LF: begin
        nx_x = '0;
        if (cur_y == LAST_Y) ex_scroll = 1'b1;
        else                 nx_y = cur_y + Y_W'(1);
      end
      CR: nx_x = '0;
      BS: begin
        ex_data = '0;
        if (cur_x != '0) begin
          ex_wr   = 1'b1;
          nx_x    = cur_x - X_W'(1);
          ex_addr = cell_addr(nx_x, cur_y);
        end else if (cur_y != '0) begin
          ex_wr   = 1'b1;
          nx_x    = LAST_X;
          nx_y    = cur_y - Y_W'(1);
          ex_addr = cell_addr(nx_x, nx_y);
        end
      end
      FF: begin
        ex_fill = 1'b1;
        nx_x    = '0;
        nx_y    = '0;
      end
      default: begin
        if (is_printable(char_q)) begin
          ex_wr = 1'b1;
          if (cur_x == LAST_X) begin
            nx_x = '0;
            if (cur_y == LAST_Y) ex_scroll = 1'b1;
            else                 nx_y = cur_y + Y_W'(1);
          end else begin
            nx_x = cur_x + X_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (accept) state_next = ST_EXEC;
      ST_EXEC: begin
        if (ex_scroll)    state_next = ST_SCROLL_RD;
        else if (ex_fill) state_next = ST_FILL;
        else              state_next = ST_IDLE;
      end
      ST_SCROLL_RD: state_next = ST_SCROLL_WR;
      ST_SCROLL_WR: state_next = (idx == SCROLL_LAST) ? ST_FILL : ST_SCROLL_RD;
      ST_FILL:      if (idx == FILL_LAST) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Memory port decode; depends only on registered state, never on char_in.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      ST_EXEC: begin
        mem_addr  = ex_addr;
        mem_wdata = ex_wr ? ex_data : '0;
        mem_wren  = ex_wr;
      end
      ST_SCROLL_RD: mem_addr = idx + ROW_STRIDE;
      ST_SCROLL_WR: begin
        mem_addr  = idx;
        mem_wdata = mem_rdata;
        mem_wren  = 1'b1;
      end
      ST_FILL: begin
        mem_addr = idx;
        mem_wren = 1'b1;
      end
      default: ;
    endcase
  end

  // Cursor, sweep index, latched character and ready flag.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      cur_x   <= '0;
      cur_y   <= '0;
      idx     <= '0;
      char_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state_next == ST_IDLE);
      case (state)
        ST_IDLE: if (accept) char_q <= char_in;
        ST_EXEC: begin
          cur_x <= nx_x;
          cur_y <= nx_y;
          idx   <= '0;
        end
        ST_SCROLL_WR: idx <= idx + ADDR_W'(1);
        ST_FILL:      idx <= idx + ADDR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer: stimulus queues expected buffer writes,
// a monitor pops and compares them on every observed write strobe.
module tb_vga_text_writer;
  import vga_text_writer_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              CLOCK_50   = 1'b0;
  logic              RESET      = 1'b1;
  logic [7:0]        char_in    = 8'h00;
  logic              char_valid = 1'b0;
  logic              char_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_wren;
  logic [7:0]        mem_rdata;
  logic [X_W-1:0]    cursor_x;
  logic [Y_W-1:0]    cursor_y;
  logic              busy;
  logic              preload = 1'b0;

  logic [7:0] mem [0:2047];
  wr_t        exp_q [$];
  int         checks   = 0;
  int         failures = 0;
  int         wr_count = 0;

  vga_text_writer dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Synchronous text buffer; preload fills row r with r+1.
  always @(posedge CLOCK_50) begin
    if (preload) begin
      for (int i = 0; i < int'(CELLS); i++) mem[i] <= 8'(i / int'(COLS) + 1);
    end else begin
      if (mem_wren) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push_wr(input int a, input int d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = 8'(d);
    exp_q.push_back(e);
  endfunction

  always @(negedge CLOCK_50) begin
    if (!RESET && mem_wren) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    while (!char_ready && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!char_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready=%0b expected 1", char_ready);
    end
    char_in    = c;
    char_valid = 1'b1;
    @(negedge CLOCK_50);
    char_valid = 1'b0;
  endtask

  // Returns the number of negedges until char_ready rises.
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!char_ready && n < 5000);
    if (!char_ready) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: got ready=%0b expected 1", char_ready);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLOCK_50);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    check({tag, "_rst_ready"}, 32'(char_ready), 0);
    check({tag, "_rst_wren"},  32'(mem_wren), 0);
    check({tag, "_rst_cx"},    32'(cursor_x), 0);
    RESET = 1'b0;
    @(negedge CLOCK_50);
    check({tag, "_rel_ready"}, 32'(char_ready), 1);
  endtask

  task automatic check_cursor(input string tag, input int x, input int y);
    check({tag, "_x"}, 32'(cursor_x), 32'(x));
    check({tag, "_y"}, 32'(cursor_y), 32'(y));
  endtask

  task automatic go_bottom();
    int n;
    for (int i = 0; i < 23; i++) send(LF);
    wait_idle(n);
  endtask

  task automatic do_preload();
    preload = 1'b1;
    @(negedge CLOCK_50);
    preload = 1'b0;
  endtask

  initial begin
    int n;
    int wc0;
    bit found;

    // Reset state
    @(negedge CLOCK_50);
    check("rst_ready", 32'(char_ready), 0);
    check("rst_busy",  32'(busy), 1);
    check("rst_wren",  32'(mem_wren), 0);
    check("rst_addr",  32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check_cursor("rst", 0, 0);
    RESET = 1'b0;
    @(negedge CLOCK_50);
    check("rel_ready", 32'(char_ready), 1);

    // 'A' at origin
    push_wr(0, 8'h41);
    send(8'h41);
    check("A_ready_exec", 32'(char_ready), 0);
    check("A_wren_exec",  32'(mem_wren), 1);
    @(negedge CLOCK_50);
    check("A_ready_back", 32'(char_ready), 1);
    check_cursor("A", 1, 0);

    send(CR);
    wait_idle(n);
    check("CR_lat", 32'(n - 1), 0);
    check_cursor("CR", 0, 0);

    // Walk to (63,5), then wrap with 'B'
    for (int i = 0; i < 5; i++) send(LF);
    for (int i = 0; i < 63; i++) begin
      push_wr(320 + i, 8'h2E);
      send(8'h2E);
    end
    wait_idle(n);
    check_cursor("pre_B", 63, 5);
    push_wr(383, 8'h42);
    send(8'h42);
    wait_idle(n);
    check("B_lat", 32'(n - 1), 0);
    check_cursor("B", 0, 6);

    // Printable edge and ignored codes
    push_wr(384, 8'h7E);
    send(8'h7E);
    send(8'h7F);
    send(8'h01);
    wait_idle(n);
    check_cursor("ign", 1, 6);

    // Backspace across a row boundary, then within a row
    do_reset("bs");
    for (int i = 0; i < 3; i++) send(LF);
    push_wr(191, 0);
    send(BS);
    wait_idle(n);
    check_cursor("BS_row", 63, 2);
    push_wr(190, 0);
    send(BS);
    wait_idle(n);
    check_cursor("BS_col", 62, 2);

    do_reset("bs0");
    send(BS);
    wait_idle(n);
    check_cursor("BS_origin", 0, 0);

    // Scroll from (10,23)
    do_reset("scr");
    go_bottom();
    for (int i = 0; i < 10; i++) begin
      push_wr(1472 + i, 8'h2E);
      send(8'h2E);
    end
    wait_idle(n);
    check_cursor("pre_scroll", 10, 23);
    do_preload();
    for (int i = 0; i < 1472; i++) push_wr(i, i / 64 + 2);
    for (int i = 1472; i < 1536; i++) push_wr(i, 0);
    send(LF);
    wait_idle(n);
    check("scroll_busy", 32'(n - 1), 3008);
    check_cursor("scroll", 0, 23);
    check("row0",    32'(mem[0]), 2);
    check("row1",    32'(mem[64]), 3);
    check("row22",   32'(mem[1471]), 24);
    check("row23a",  32'(mem[1472]), 0);
    check("row23b",  32'(mem[1535]), 0);
    check("scroll_q", 32'(exp_q.size()), 0);

    // Form feed
    wc0 = wr_count;
    for (int i = 0; i < 1536; i++) push_wr(i, 0);
    send(FF);
    wait_idle(n);
    check("ff_busy", 32'(n - 1), 1536);
    check("ff_writes", 32'(wr_count - wc0), 1536);
    check_cursor("ff", 0, 0);
    check("ff_q", 32'(exp_q.size()), 0);

    // Reset in the middle of a scroll, while reading idx 700
    do_reset("mid");
    go_bottom();
    do_preload();
    for (int i = 0; i < 700; i++) push_wr(i, i / 64 + 2);
    send(LF);
    n = 0;
    found = 1'b0;
    while (!found && n < 5000) begin
      @(negedge CLOCK_50);
      n++;
      if (mem_addr == ADDR_W'(764) && !mem_wren) found = 1'b1;
    end
    check("mid_found", 32'(found), 1);
    RESET = 1'b1;
    #1;
    check("mid_wren", 32'(mem_wren), 0);
    check("mid_addr", 32'(mem_addr), 0);
    check("mid_ready", 32'(char_ready), 0);
    check_cursor("mid", 0, 0);
    check("mid_699",  32'(mem[699]), 12);
    check("mid_700",  32'(mem[700]), 11);
    check("mid_1535", 32'(mem[1535]), 24);
    check("mid_q", 32'(exp_q.size()), 0);
    @(negedge CLOCK_50);
    RESET = 1'b0;
    @(negedge CLOCK_50);
    check("mid_rel_ready", 32'(char_ready), 1);
    @(negedge CLOCK_50);
    check("mid_700_kept", 32'(mem[700]), 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
